mul_seq: RTL and testbench

- Iterative shift-add multiplier sequencer for the E stage of the 5-stage pipeline; handles MUL without lengthening the single-cycle ALU path.
- Accepts one operation from E, runs it over several cycles, and tracks the pending destination register as a one-entry scoreboard.
- Raises stall and match requests consumed by the hazard unit.
- Returns the result through a W-stage register-file write port shared with the main pipeline, using a valid/ack handshake.

---
 rtl/mul_seq_if.sv | 32 +++
 rtl/mul_seq.sv | 95 +++++++++
 tb/tb_mul_seq.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mul_seq_if.sv
// Handshake/bus bundle between the E/W pipeline stages and the mul_seq sequencer.
// master = pipeline side (drives requests), slave = multiplier side.
interface mul_seq_if #(
  parameter int WIDTH = 32,
  parameter int RA_W  = 4
);
  logic             StartE;
  logic             FlushE;
  logic             Kill;
  logic [WIDTH-1:0] SrcAE;
  logic [WIDTH-1:0] SrcBE;
  logic [RA_W-1:0]  RdE;
  logic [RA_W-1:0]  RA1D;
  logic [RA_W-1:0]  RA2D;
  logic             WrAckW;
  logic             BusyE;
  logic             StallReqE;
  logic             MatchPendD;
  logic             ResultValidW;
  logic [WIDTH-1:0] ResultW;
  logic [RA_W-1:0]  WA3W;

  modport master (
    output StartE, FlushE, Kill, SrcAE, SrcBE, RdE, RA1D, RA2D, WrAckW,
    input  BusyE, StallReqE, MatchPendD, ResultValidW, ResultW, WA3W
  );

  modport slave (
    input  StartE, FlushE, Kill, SrcAE, SrcBE, RdE, RA1D, RA2D, WrAckW,
    output BusyE, StallReqE, MatchPendD, ResultValidW, ResultW, WA3W
  );
endinterface

// File: rtl/mul_seq.sv
// Iterative shift-add MUL sequencer with one-entry pending-Rd scoreboard; latency WIDTH cycles,
// or 1 + msb index of SrcBE when MUL_EARLY_TERM_EN is defined. Result held until WrAckW.
module mul_seq #(
  parameter int WIDTH = 32,
  parameter int RA_W  = 4
) (
  input logic      clk,
  input logic      reset,
  mul_seq_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state;
  logic               pending;
  logic [RA_W-1:0]    pend_rd;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [WIDTH-1:0]   product;
  logic [CNT_W-1:0]   count;

  logic [2*WIDTH-1:0] acc_nxt;
  logic [WIDTH-1:0]   mplier_nxt;
  logic               last_step;

  // mcand is pre-shifted one place per step, so it always equals SrcAE << count.
  always_comb begin
    acc_nxt    = mplier[0] ? acc + mcand : acc;
    mplier_nxt = mplier >> 1;
`ifdef MUL_EARLY_TERM_EN
    last_step  = (count == CNT_W'(WIDTH - 1)) || (mplier_nxt == '0);
`else
    last_step  = (count == CNT_W'(WIDTH - 1));
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      pending <= 1'b0;
      pend_rd <= '0;
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      product <= '0;
      count   <= '0;
    end else if (bus.Kill) begin
      state   <= IDLE;
      pending <= 1'b0;
      product <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.StartE && !bus.FlushE) begin
            acc     <= '0;
            mcand   <= {{WIDTH{1'b0}}, bus.SrcAE};
            mplier  <= bus.SrcBE;
            pend_rd <= bus.RdE;
            pending <= 1'b1;
            count   <= '0;
            state   <= RUN;
          end
        end
        RUN: begin
          acc    <= acc_nxt;
          mcand  <= mcand << 1;
          mplier <= mplier_nxt;
          count  <= count + 1'b1;
          if (last_step) begin
            product <= acc_nxt[WIDTH-1:0];
            state   <= DONE;
          end
        end
        DONE: begin
          // Ack frees the unit but never accepts in the same cycle.
          if (bus.WrAckW) begin
            state   <= IDLE;
            pending <= 1'b0;
            product <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.BusyE        = (state != IDLE);
  assign bus.StallReqE    = bus.StartE & ~bus.FlushE & (state != IDLE);
  assign bus.MatchPendD   = pending & ((bus.RA1D == pend_rd) | (bus.RA2D == pend_rd));
  assign bus.ResultValidW = (state == DONE);
  assign bus.ResultW      = product;
  assign bus.WA3W         = pend_rd;
endmodule

// File: tb/tb_mul_seq.sv
// Scoreboard bench for mul_seq: expected products queued at issue, compared when ResultValidW rises.
module tb_mul_seq;
  localparam int WIDTH = 32;
  localparam int RA_W  = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mul_seq_if #(.WIDTH(WIDTH), .RA_W(RA_W)) bus ();
  mul_seq #(.WIDTH(WIDTH), .RA_W(RA_W)) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct packed {
    logic [WIDTH-1:0] res;
    logic [RA_W-1:0]  rd;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad   = 0;

  function automatic int exp_lat(input logic [WIDTH-1:0] b);
    int l;
    l = WIDTH;
`ifdef MUL_EARLY_TERM_EN
    l = 1;
    for (int i = 0; i < WIDTH; i++) if (b[i]) l = i + 1;
`endif
    return l;
  endfunction

  function automatic exp_t sb_pop();
    if (sb.size() == 0) return '0;
    return sb.pop_front();
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic [RA_W-1:0] rd);
    logic [2*WIDTH-1:0] p;
    exp_t e;
    p = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    e.res = p[WIDTH-1:0];
    e.rd  = rd;
    sb.push_back(e);
  endtask

  task automatic start_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic [RA_W-1:0] rd);
    bus.StartE = 1'b1;
    bus.SrcAE  = a;
    bus.SrcBE  = b;
    bus.RdE    = rd;
    tick();
    bus.StartE = 1'b0;
    push_exp(a, b, rd);
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (bus.ResultValidW !== 1'b1 && cyc < 200) begin
      tick();
      cyc++;
    end
  endtask

  task automatic ack();
    bus.WrAckW = 1'b1;
    tick();
    bus.WrAckW = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.StartE = 0; bus.FlushE = 0; bus.Kill = 0; bus.WrAckW = 0;
    bus.SrcAE = '0; bus.SrcBE = '0; bus.RdE = '0; bus.RA1D = '0; bus.RA2D = '0;
    tick();
    tick();
    reset = 1'b0;
    tick();
    total++; if (bus.BusyE !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", bus.BusyE); end
    total++; if (bus.StallReqE !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b exp=0", bus.StallReqE); end
    total++; if (bus.MatchPendD !== 1'b0) begin bad++; $display("FAIL reset_match got=%b exp=0", bus.MatchPendD); end
    total++; if (bus.ResultValidW !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", bus.ResultValidW); end
    total++; if (bus.ResultW !== '0) begin bad++; $display("FAIL reset_result got=%h exp=0", bus.ResultW); end
    total++; if (bus.WA3W !== '0) begin bad++; $display("FAIL reset_wa3 got=%h exp=0", bus.WA3W); end
  endtask

  task automatic test_basic();
    int cyc;
    exp_t e;
    start_op(32'd7, 32'd6, 4'd3);
    total++; if (bus.BusyE !== 1'b1) begin bad++; $display("FAIL basic_busy got=%b exp=1", bus.BusyE); end
    wait_valid(cyc);
    e = sb_pop();
    total++; if (cyc !== exp_lat(32'd6)) begin bad++; $display("FAIL basic_lat got=%0d exp=%0d", cyc, exp_lat(32'd6)); end
    total++; if (bus.ResultW !== 32'd42 || bus.ResultW !== e.res) begin bad++; $display("FAIL basic_res got=%0d exp=%0d", bus.ResultW, e.res); end
    total++; if (bus.WA3W !== 4'd3) begin bad++; $display("FAIL basic_wa3 got=%0d exp=3", bus.WA3W); end
    ack();
    total++; if (bus.BusyE !== 1'b0) begin bad++; $display("FAIL basic_idle got=%b exp=0", bus.BusyE); end
  endtask

  task automatic test_wrap();
    logic [WIDTH-1:0] ta[5];
    logic [WIDTH-1:0] tb_[5];
    int cyc;
    exp_t e;
    ta[0] = 32'hFFFF_FFFF; tb_[0] = 32'hFFFF_FFFF;
    ta[1] = 32'h8000_0000; tb_[1] = 32'd2;
    ta[2] = 32'h1234_5678; tb_[2] = 32'd0;
    ta[3] = $urandom;      tb_[3] = $urandom;
    ta[4] = $urandom;      tb_[4] = $urandom_range(255, 1);
    for (int i = 0; i < 5; i++) begin
      start_op(ta[i], tb_[i], RA_W'(i + 1));
      wait_valid(cyc);
      e = sb_pop();
      total++; if (cyc !== exp_lat(tb_[i])) begin bad++; $display("FAIL wrap_lat[%0d] got=%0d exp=%0d", i, cyc, exp_lat(tb_[i])); end
      total++; if (bus.ResultW !== e.res) begin bad++; $display("FAIL wrap_res[%0d] got=%h exp=%h", i, bus.ResultW, e.res); end
      total++; if (bus.WA3W !== e.rd) begin bad++; $display("FAIL wrap_wa3[%0d] got=%0d exp=%0d", i, bus.WA3W, e.rd); end
      ack();
    end
    total++; if (sb.size() != 0) begin bad++; $display("FAIL wrap_sb_left got=%0d exp=0", sb.size()); end
  endtask

  task automatic test_back_to_back();
    int n;
    int cyc;
    int stall_bad;
    exp_t e;
    start_op(32'd123457, 32'h0F0F_0F0F, 4'd7);
    tick();
    tick();
    bus.StartE = 1'b1;
    bus.SrcAE  = 32'hCAFE_0001;
    bus.SrcBE  = 32'h0000_0F0D;
    bus.RdE    = 4'd9;
    n = 0;
    stall_bad = 0;
    while (bus.ResultValidW !== 1'b1 && n < 200) begin
      #1;
      if (bus.StallReqE !== 1'b1) stall_bad++;
      tick();
      n++;
    end
    total++; if (stall_bad != 0) begin bad++; $display("FAIL b2b_stall_run got=%0d exp=0", stall_bad); end
    total++; if (bus.StallReqE !== 1'b1) begin bad++; $display("FAIL b2b_stall_done got=%b exp=1", bus.StallReqE); end
    total++; if (n + 2 !== exp_lat(32'h0F0F_0F0F)) begin bad++; $display("FAIL b2b_lat1 got=%0d exp=%0d", n + 2, exp_lat(32'h0F0F_0F0F)); end
    e = sb_pop();
    total++; if (bus.ResultW !== e.res) begin bad++; $display("FAIL b2b_res1 got=%h exp=%h", bus.ResultW, e.res); end
    ack();
    bus.StartE = 1'b1;
    #1;
    total++; if (bus.BusyE !== 1'b0) begin bad++; $display("FAIL b2b_no_same_cycle got=%b exp=0", bus.BusyE); end
    total++; if (bus.StallReqE !== 1'b0) begin bad++; $display("FAIL b2b_stall_idle got=%b exp=0", bus.StallReqE); end
    push_exp(32'hCAFE_0001, 32'h0000_0F0D, 4'd9);
    tick();
    bus.StartE = 1'b0;
    total++; if (bus.BusyE !== 1'b1) begin bad++; $display("FAIL b2b_accept2 got=%b exp=1", bus.BusyE); end
    wait_valid(cyc);
    e = sb_pop();
    total++; if (cyc !== exp_lat(32'h0000_0F0D)) begin bad++; $display("FAIL b2b_lat2 got=%0d exp=%0d", cyc, exp_lat(32'h0000_0F0D)); end
    total++; if (bus.ResultW !== e.res || bus.WA3W !== e.rd) begin bad++; $display("FAIL b2b_res2 got=%h/%0d exp=%h/%0d", bus.ResultW, bus.WA3W, e.res, e.rd); end
    ack();
  endtask

  task automatic test_scoreboard();
    int n;
    int match_bad;
    exp_t e;
    bus.RA1D = 4'd0;
    bus.RA2D = 4'd5;
    #1;
    total++; if (bus.MatchPendD !== 1'b0) begin bad++; $display("FAIL sb_idle got=%b exp=0", bus.MatchPendD); end
    start_op(32'd1000, 32'h8000_0001, 4'd5);
    n = 0;
    match_bad = 0;
    while (bus.ResultValidW !== 1'b1 && n < 200) begin
      if (n == 6) begin
        bus.RA1D = 4'd4;
        bus.RA2D = 4'd4;
        #1;
        total++; if (bus.MatchPendD !== 1'b0) begin bad++; $display("FAIL sb_nomatch got=%b exp=0", bus.MatchPendD); end
        bus.RA1D = 4'd0;
        bus.RA2D = 4'd5;
        #1;
      end
      if (bus.MatchPendD !== 1'b1) match_bad++;
      tick();
      n++;
    end
    total++; if (match_bad != 0) begin bad++; $display("FAIL sb_match_run got=%0d exp=0", match_bad); end
    total++; if (bus.MatchPendD !== 1'b1) begin bad++; $display("FAIL sb_match_done got=%b exp=1", bus.MatchPendD); end
    bus.RA1D = 4'd5;
    bus.RA2D = 4'd0;
    #1;
    total++; if (bus.MatchPendD !== 1'b1) begin bad++; $display("FAIL sb_match_ra1 got=%b exp=1", bus.MatchPendD); end
    e = sb_pop();
    total++; if (bus.ResultW !== e.res) begin bad++; $display("FAIL sb_res got=%h exp=%h", bus.ResultW, e.res); end
    ack();
    total++; if (bus.MatchPendD !== 1'b0) begin bad++; $display("FAIL sb_after_ack got=%b exp=0", bus.MatchPendD); end
    bus.RA1D = 4'd0;
  endtask

  task automatic test_kill();
    int seen;
    bus.RA2D = 4'd2;
    start_op(32'hDEAD_BEEF, 32'hFFFF_FFFF, 4'd2);
    repeat (9) tick();
    bus.Kill = 1'b1;
    tick();
    bus.Kill = 1'b0;
    void'(sb.pop_back());
    total++; if (bus.BusyE !== 1'b0) begin bad++; $display("FAIL kill_idle got=%b exp=0", bus.BusyE); end
    total++; if (bus.MatchPendD !== 1'b0) begin bad++; $display("FAIL kill_pending got=%b exp=0", bus.MatchPendD); end
    seen = 0;
    repeat (40) begin
      if (bus.ResultValidW !== 1'b0) seen++;
      tick();
    end
    total++; if (seen != 0) begin bad++; $display("FAIL kill_no_valid got=%0d exp=0", seen); end
    bus.StartE = 1'b1;
    bus.Kill   = 1'b1;
    tick();
    bus.StartE = 1'b0;
    bus.Kill   = 1'b0;
    total++; if (bus.BusyE !== 1'b0) begin bad++; $display("FAIL kill_drops_start got=%b exp=0", bus.BusyE); end
    bus.StartE = 1'b1;
    bus.FlushE = 1'b1;
    tick();
    total++; if (bus.BusyE !== 1'b0) begin bad++; $display("FAIL flush_no_accept got=%b exp=0", bus.BusyE); end
    bus.StartE = 1'b0;
    bus.FlushE = 1'b0;
    start_op(32'd5, 32'hFFFF_0000, 4'd6);
    bus.StartE = 1'b1;
    bus.FlushE = 1'b1;
    #1;
    total++; if (bus.StallReqE !== 1'b0) begin bad++; $display("FAIL flush_no_stall got=%b exp=0", bus.StallReqE); end
    bus.StartE = 1'b0;
    bus.FlushE = 1'b0;
    bus.Kill   = 1'b1;
    tick();
    bus.Kill   = 1'b0;
    void'(sb.pop_back());
    bus.RA2D = 4'd0;
  endtask

  task automatic test_hold();
    int cyc;
    int unstable;
    exp_t e;
    start_op(32'h1234_5678, 32'h9ABC_DEF0, 4'd11);
    repeat (3) tick();
    bus.WrAckW = 1'b1;
    tick();
    bus.WrAckW = 1'b0;
    total++; if (bus.BusyE !== 1'b1) begin bad++; $display("FAIL hold_ack_ignored got=%b exp=1", bus.BusyE); end
    wait_valid(cyc);
    total++; if (cyc + 4 !== exp_lat(32'h9ABC_DEF0)) begin bad++; $display("FAIL hold_lat got=%0d exp=%0d", cyc + 4, exp_lat(32'h9ABC_DEF0)); end
    e = sb_pop();
    unstable = 0;
    repeat (5) begin
      if (bus.ResultValidW !== 1'b1 || bus.ResultW !== e.res || bus.WA3W !== e.rd) unstable++;
      tick();
    end
    total++; if (unstable != 0) begin bad++; $display("FAIL hold_stable got=%0d exp=0", unstable); end
    ack();
    total++; if (bus.ResultValidW !== 1'b0) begin bad++; $display("FAIL hold_cleared got=%b exp=0", bus.ResultValidW); end
  endtask

  task automatic test_reset_mid();
    int cyc;
    exp_t e;
    start_op(32'hFFFF_0001, 32'h7777_7777, 4'd8);
    repeat (5) tick();
    reset = 1'b1;
    #1;
    void'(sb.pop_back());
    total++; if (bus.BusyE !== 1'b0 || bus.ResultValidW !== 1'b0) begin bad++; $display("FAIL rstmid_idle got=%b%b exp=00", bus.BusyE, bus.ResultValidW); end
    total++; if (bus.WA3W !== '0) begin bad++; $display("FAIL rstmid_wa3 got=%0d exp=0", bus.WA3W); end
    tick();
    reset = 1'b0;
    tick();
    start_op(32'd3, 32'd5, 4'd1);
    wait_valid(cyc);
    e = sb_pop();
    total++; if (bus.ResultW !== e.res || cyc !== exp_lat(32'd5)) begin bad++; $display("FAIL rstmid_recover got=%h/%0d exp=%h/%0d", bus.ResultW, cyc, e.res, exp_lat(32'd5)); end
    ack();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_back_to_back();
    test_scoreboard();
    test_kill();
    test_hold();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
